// File: rtl/mem_access.sv
// Memory-access stage: drives the data-RAM req/ack port, extracts load data, registers the WB bundle.
// Optional misalignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_result,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic        reg_write_en,
    input  logic [4:0]  reg_write_addr,
    input  logic [31:0] current_pc_addr,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ack,
    output logic        stall_req,
    output logic        wb_reg_write_en,
    output logic [4:0]  wb_reg_write_addr,
    output logic [31:0] wb_result,
    output logic [31:0] wb_pc_addr,
    output logic        bus_error,
    output logic        align_error
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          mem_op, is_store, misalign, timeout;
    logic          ram_en_c, stall_c;
    logic [31:0]   load_data;
    logic          wb_en_nx, bus_nx, align_nx;
    logic [4:0]    wb_addr_nx;
    logic [31:0]   wb_result_nx, wb_pc_nx;

    assign mem_op   = mem_read_flag | mem_write_flag;
    assign is_store = mem_write_flag;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op &&
                      ((mem_sel == 4'b1111 && ex_result[1:0] != 2'b00) ||
                       ((mem_sel == 4'b0011 || mem_sel == 4'b1100) && ex_result[0]));
`else
    assign misalign = 1'b0;
`endif

    // Timeout fires in the last permitted WAIT_ACK cycle so upstream is released that same cycle.
    assign timeout = (ACK_TIMEOUT != 0) && (state == WAIT_ACK) &&
                     (cnt == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        load_data = '0;
        case (mem_sel)
            4'b1111: load_data = ram_read_data;
            4'b0011: load_data = {{16{mem_sign_ext_flag & ram_read_data[15]}}, ram_read_data[15:0]};
            4'b1100: load_data = {{16{mem_sign_ext_flag & ram_read_data[31]}}, ram_read_data[31:16]};
            4'b0001: load_data = {{24{mem_sign_ext_flag & ram_read_data[7]}},  ram_read_data[7:0]};
            4'b0010: load_data = {{24{mem_sign_ext_flag & ram_read_data[15]}}, ram_read_data[15:8]};
            4'b0100: load_data = {{24{mem_sign_ext_flag & ram_read_data[23]}}, ram_read_data[23:16]};
            4'b1000: load_data = {{24{mem_sign_ext_flag & ram_read_data[31]}}, ram_read_data[31:24]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = '0;
        ram_en_c     = 1'b0;
        stall_c      = 1'b0;
        bus_nx       = 1'b0;
        align_nx     = 1'b0;
        wb_en_nx     = wb_reg_write_en;
        wb_addr_nx   = wb_reg_write_addr;
        wb_result_nx = wb_result;
        wb_pc_nx     = wb_pc_addr;
        case (state)
            IDLE: begin
                if (!mem_op) begin
                    wb_en_nx     = reg_write_en;
                    wb_addr_nx   = reg_write_addr;
                    wb_result_nx = ex_result;
                    wb_pc_nx     = current_pc_addr;
                end else if (misalign) begin
                    align_nx = 1'b1;
                    wb_en_nx = 1'b0;
                end else begin
                    ram_en_c = 1'b1;
                    if (ram_ack) begin
                        wb_en_nx     = reg_write_en;
                        wb_addr_nx   = reg_write_addr;
                        wb_result_nx = is_store ? ex_result : load_data;
                        wb_pc_nx     = current_pc_addr;
                    end else begin
                        stall_c  = 1'b1;
                        wb_en_nx = 1'b0;
                        state_nx = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                ram_en_c = 1'b1;
                if (ram_ack) begin
                    wb_en_nx     = reg_write_en;
                    wb_addr_nx   = reg_write_addr;
                    wb_result_nx = is_store ? ex_result : load_data;
                    wb_pc_nx     = current_pc_addr;
                    state_nx     = IDLE;
                end else if (timeout) begin
                    bus_nx   = 1'b1;
                    wb_en_nx = 1'b0;
                    state_nx = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_nx  = (ACK_TIMEOUT != 0) ? cnt + CW'(1) : '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ram_en         = rst & ram_en_c;
    assign stall_req      = rst & stall_c;
    assign ram_write_en   = (ram_en && is_store) ? mem_sel : '0;
    assign ram_addr       = {ex_result[31:2], 2'b00};
    assign ram_write_data = mem_write_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= '0;
            wb_reg_write_en   <= 1'b0;
            wb_reg_write_addr <= '0;
            wb_result         <= '0;
            wb_pc_addr        <= '0;
            bus_error         <= 1'b0;
            align_error       <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            wb_reg_write_en   <= wb_en_nx;
            wb_reg_write_addr <= wb_addr_nx;
            wb_result         <= wb_result_nx;
            wb_pc_addr        <= wb_pc_nx;
            bus_error         <= bus_nx;
            align_error       <= align_nx;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed scenarios plus randomized loads/stores/ALU passes.
module tb_mem_access;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_result;
    logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] current_pc_addr;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data, ram_read_data;
    logic        ram_ack, stall_req;
    logic        wb_reg_write_en;
    logic [4:0]  wb_reg_write_addr;
    logic [31:0] wb_result, wb_pc_addr;
    logic        bus_error, align_error;

    mem_access #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .ex_result(ex_result),
        .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
        .mem_write_data(mem_write_data), .reg_write_en(reg_write_en),
        .reg_write_addr(reg_write_addr), .current_pc_addr(current_pc_addr),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .ram_ack(ram_ack), .stall_req(stall_req),
        .wb_reg_write_en(wb_reg_write_en), .wb_reg_write_addr(wb_reg_write_addr),
        .wb_result(wb_result), .wb_pc_addr(wb_pc_addr),
        .bus_error(bus_error), .align_error(align_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] result;
        logic [31:0] pc;
        logic        berr;
        logic        aerr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference load extraction: shift the selected lane down, mask to its width, extend.
    function automatic logic [31:0] load_model(logic [3:0] sel, bit sx, logic [31:0] d);
        int unsigned w, s;
        logic [31:0] v, m;
        case (sel)
            4'b1111: begin w = 32; s = 0;  end
            4'b0011: begin w = 16; s = 0;  end
            4'b1100: begin w = 16; s = 16; end
            4'b0001: begin w = 8;  s = 0;  end
            4'b0010: begin w = 8;  s = 8;  end
            4'b0100: begin w = 8;  s = 16; end
            4'b1000: begin w = 8;  s = 24; end
            default: return 32'h0;
        endcase
        v = d >> s;
        if (w == 32) return v;
        m = (32'd1 << w) - 32'd1;
        v = v & m;
        if (sx && v[w-1]) v = v | ~m;
        return v;
    endfunction

    // Monitor: every cycle the DUT presents a WB write or an error pulse, pop one expectation.
    always @(negedge clk) begin
        if (rst && (wb_reg_write_en || bus_error || align_error)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_reg_write_en", wb_reg_write_en, e.en);
                chk("bus_error", bus_error, e.berr);
                chk("align_error", align_error, e.aerr);
                if (e.en) begin
                    chk("wb_reg_write_addr", wb_reg_write_addr, e.addr);
                    chk("wb_result", wb_result, e.result);
                    chk("wb_pc_addr", wb_pc_addr, e.pc);
                end
            end
        end
    end

    // Called and returns at posedge+1; one op plus a bubble cycle afterwards.
    task automatic run_op(input bit rd, input bit wr, input bit sx, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int unsigned delay,
                          input logic [4:0] waddr, input logic [31:0] pc);
        bit mem_op, mis, active, is_ack, done;
        int unsigned c;
        exp_t e;
        mem_op = rd | wr;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = mem_op && ((sel == 4'b1111 && addr[1:0] != 2'b00) ||
                         ((sel == 4'b0011 || sel == 4'b1100) && addr[0]));
`endif
        active = mem_op && !mis;
        ex_result = addr; mem_read_flag = rd; mem_write_flag = wr;
        mem_sign_ext_flag = sx; mem_sel = sel; mem_write_data = wdata;
        reg_write_en = 1'b1; reg_write_addr = waddr; current_pc_addr = pc;
        c = 0; done = 1'b0;
        while (!done) begin
            is_ack = active && (c == delay);
            ram_ack = is_ack;
            ram_read_data = is_ack ? rdata : $urandom;
            #1;
            chk("ram_en", ram_en, active);
            chk("stall_req", stall_req, active && !is_ack && c != T);
            chk("ram_write_en", ram_write_en, (active && wr) ? sel : 4'b0000);
            chk("ram_addr", ram_addr, {addr[31:2], 2'b00});
            chk("ram_write_data", ram_write_data, wdata);
            if (!active || is_ack) begin
                e.en = !mis; e.addr = waddr; e.pc = pc; e.berr = 1'b0; e.aerr = mis;
                e.result = (rd && !wr) ? load_model(sel, sx, rdata) : addr;
                q.push_back(e);
                done = 1'b1;
            end else if (c == T) begin
                e.en = 1'b0; e.addr = '0; e.result = '0; e.pc = '0; e.berr = 1'b1; e.aerr = 1'b0;
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
            c++;
        end
        mem_read_flag = 1'b0; mem_write_flag = 1'b0; reg_write_en = 1'b0; ram_ack = 1'b0;
        #1;
        chk("idle_ram_en", ram_en, 1'b0);
        chk("idle_stall_req", stall_req, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] sels [10];
        sels = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010,
                 4'b0100, 4'b1000, 4'b0101, 4'b0000, 4'b0110};
        rst = 1'b0;
        ex_result = 32'h100; mem_read_flag = 1'b1; mem_write_flag = 1'b0;
        mem_sign_ext_flag = 1'b0; mem_sel = 4'b1111; mem_write_data = '0;
        reg_write_en = 1'b1; reg_write_addr = 5'd3; current_pc_addr = 32'h40;
        ram_read_data = '0; ram_ack = 1'b0;
        #3;
        chk("reset_ram_en", ram_en, 1'b0);
        chk("reset_stall_req", stall_req, 1'b0);
        chk("reset_ram_write_en", ram_write_en, 4'b0000);
        chk("reset_wb_en", wb_reg_write_en, 1'b0);
        chk("reset_wb_result", wb_result, 32'h0);
        chk("reset_bus_error", bus_error, 1'b0);
        chk("reset_align_error", align_error, 1'b0);
        @(posedge clk); #1;
        mem_read_flag = 1'b0; reg_write_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(0, 0, 0, 4'b0000, 32'h12345678, 32'h0, 32'h0, 0, 5'd5, 32'h1000);
        run_op(1, 0, 1, 4'b0010, 32'h200, 32'h0, 32'h0000_8000, 0, 5'd7, 32'h1004);
        run_op(1, 0, 0, 4'b0010, 32'h200, 32'h0, 32'h0000_8000, 0, 5'd8, 32'h1008);
        run_op(0, 1, 0, 4'b1100, 32'h100, 32'hBEEF_0000, 32'h0, 3, 5'd9, 32'h100C);
        run_op(1, 0, 0, 4'b1111, 32'h300, 32'h0, 32'h0, 99, 5'd10, 32'h1010);
        run_op(1, 0, 1, 4'b0011, 32'h304, 32'h0, 32'h0000_F00D, 1, 5'd11, 32'h1014);
        run_op(1, 0, 0, 4'b1111, 32'h102, 32'h0, 32'hCAFE_BABE, 1, 5'd12, 32'h1018);
        run_op(1, 1, 0, 4'b0001, 32'h400, 32'h0000_00AA, 32'h0, T, 5'd13, 32'h101C);

        // Reset while stalled in WAIT_ACK: outputs clear without a clock edge.
        ex_result = 32'h500; mem_read_flag = 1'b1; mem_sel = 4'b1111;
        reg_write_en = 1'b1; ram_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midrst_ram_en", ram_en, 1'b0);
        chk("midrst_stall_req", stall_req, 1'b0);
        chk("midrst_wb_en", wb_reg_write_en, 1'b0);
        chk("midrst_wb_addr", wb_reg_write_addr, 5'd0);
        chk("midrst_wb_result", wb_result, 32'h0);
        chk("midrst_wb_pc", wb_pc_addr, 32'h0);
        mem_read_flag = 1'b0; reg_write_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("postrst_idle_ram_en", ram_en, 1'b0);
        chk("postrst_idle_stall", stall_req, 1'b0);
        run_op(1, 0, 1, 4'b1000, 32'h600, 32'h0, 32'h8100_0000, 0, 5'd14, 32'h1020);

        for (int i = 0; i < 150; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            run_op(kind == 1 || kind == 3, kind >= 2, 1'($urandom_range(0, 1)),
                   sels[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
                   $urandom_range(0, 6), 5'($urandom), $urandom);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
